// File: rtl/rob_multiport.sv
// rob_multiport: in-order reorder buffer with CDB_PORTS result buses per cycle.
// Tags are allocated in program order and equal the slot index. One entry retires per cycle.
// A retired store blocks further retirement until memory reports completion.
// Optional feature macro: ROB_QUERY_EN adds combinational operand-forward lookup ports.
module rob_multiport #(
  parameter int unsigned ROB_DEPTH  = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned CDB_PORTS  = 2,
  parameter logic [2:0]  STORE_TYPE = 3'd2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       iss_valid,
  input  logic [31:0]                iss_pc,
  input  logic [4:0]                 iss_rd,
  input  logic [5:0]                 iss_op,
  input  logic [2:0]                 iss_type,
  output logic                       iss_ready,
  output logic [TAG_W-1:0]           iss_tag,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]    cdb_value,
  input  logic [CDB_PORTS*32-1:0]    cdb_pc_res,
  input  logic                       store_done_in,
  output logic                       cmt_valid,
  output logic [TAG_W-1:0]           cmt_tag,
  output logic [4:0]                 cmt_rd,
  output logic [5:0]                 cmt_op,
  output logic [2:0]                 cmt_type,
  output logic [31:0]                cmt_value,
  output logic [31:0]                cmt_pc,
  output logic [31:0]                cmt_pc_res,
  output logic [TAG_W:0]             occupancy,
`ifdef ROB_QUERY_EN
  input  logic [TAG_W-1:0]           qry_tag_a,
  input  logic [TAG_W-1:0]           qry_tag_b,
  output logic                       qry_ready_a,
  output logic                       qry_ready_b,
  output logic [31:0]                qry_value_a,
  output logic [31:0]                qry_value_b,
`endif
  output logic                       empty
);

  localparam int unsigned CNT_W = TAG_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [2:0]  typ;
    logic [31:0] value;
    logic [31:0] pc_res;
  } entry_t;

  entry_t                 slot_q [ROB_DEPTH];
  entry_t                 slot_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]   valid_q, valid_d;
  logic [ROB_DEPTH-1:0]   ready_q, ready_d;
  logic [TAG_W-1:0]       head_q, head_d;
  logic [TAG_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   store_pending_q, store_pending_d;
  logic                   cmt_valid_q, cmt_valid_d;
  logic [TAG_W-1:0]       cmt_tag_q, cmt_tag_d;
  entry_t                 cmt_q, cmt_d;

  logic retire_ok;
  logic retire_en;
  logic alloc_en;
  logic store_set;

  // Head is retirable from registered state only; a freed head slot may be re-allocated in the same cycle.
  assign retire_ok = valid_q[head_q] & ready_q[head_q] & ~store_pending_q;
  assign iss_ready = (count_q != CNT_W'(ROB_DEPTH)) | retire_ok;
  assign alloc_en  = rdy_in & ~flush_in & iss_valid & iss_ready;
  assign retire_en = rdy_in & ~flush_in & retire_ok;

  assign iss_tag    = tail_q;
  assign occupancy  = count_q;
  assign empty      = (count_q == '0);
  assign cmt_valid  = cmt_valid_q;
  assign cmt_tag    = cmt_tag_q;
  assign cmt_rd     = cmt_q.rd;
  assign cmt_op     = cmt_q.op;
  assign cmt_type   = cmt_q.typ;
  assign cmt_value  = cmt_q.value;
  assign cmt_pc     = cmt_q.pc;
  assign cmt_pc_res = cmt_q.pc_res;

  // Next state: CDB writes, then retire, then allocation (allocation overrides both on a shared slot).
  always_comb begin
    slot_d          = slot_q;
    valid_d         = valid_q;
    ready_d         = ready_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    store_pending_d = store_pending_q;
    cmt_valid_d     = cmt_valid_q;
    cmt_tag_d       = cmt_tag_q;
    cmt_d           = cmt_q;
    store_set       = 1'b0;

    if (rdy_in) begin
      cmt_valid_d = 1'b0;
      if (flush_in) begin
        valid_d = '0;
        ready_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        for (int p = 0; p < int'(CDB_PORTS); p++) begin
          if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
            ready_d[cdb_tag[p*TAG_W +: TAG_W]]        = 1'b1;
            slot_d[cdb_tag[p*TAG_W +: TAG_W]].value  = cdb_value[p*32 +: 32];
            slot_d[cdb_tag[p*TAG_W +: TAG_W]].pc_res = cdb_pc_res[p*32 +: 32];
          end
        end

        if (retire_en) begin
          cmt_valid_d     = 1'b1;
          cmt_tag_d       = head_q;
          cmt_d           = slot_q[head_q];
          valid_d[head_q] = 1'b0;
          ready_d[head_q] = 1'b0;
          head_d          = head_q + TAG_W'(1);
          store_set       = (slot_q[head_q].typ == STORE_TYPE);
        end

        if (alloc_en) begin
          slot_d[tail_q]  = '{pc: iss_pc, rd: iss_rd, op: iss_op, typ: iss_type,
                              value: 32'd0, pc_res: 32'd0};
          valid_d[tail_q] = 1'b1;
          ready_d[tail_q] = 1'b0;
          tail_d          = tail_q + TAG_W'(1);
        end

        if (alloc_en && !retire_en) begin
          count_d = count_q + CNT_W'(1);
        end else if (!alloc_en && retire_en) begin
          count_d = count_q - CNT_W'(1);
        end
      end

      // A store committed this cycle outranks a completion arriving in the same cycle.
      if (store_set) begin
        store_pending_d = 1'b1;
      end else if (store_done_in) begin
        store_pending_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        slot_q[i] <= '0;
      end
      valid_q         <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      store_pending_q <= 1'b0;
      cmt_valid_q     <= 1'b0;
      cmt_tag_q       <= '0;
      cmt_q           <= '0;
    end else begin
      slot_q          <= slot_d;
      valid_q         <= valid_d;
      ready_q         <= ready_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      store_pending_q <= store_pending_d;
      cmt_valid_q     <= cmt_valid_d;
      cmt_tag_q       <= cmt_tag_d;
      cmt_q           <= cmt_d;
    end
  end

`ifdef ROB_QUERY_EN
  // Operand lookup: stored result, overridden by a same-cycle CDB hit (lowest port wins).
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] tag);
    logic        rdy;
    logic [31:0] val;
    rdy = valid_q[tag] & ready_q[tag];
    val = slot_q[tag].value;
    for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
      if (cdb_valid[p] && valid_q[tag] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
        rdy = 1'b1;
        val = cdb_value[p*32 +: 32];
      end
    end
    return {rdy, val};
  endfunction

  // Both query ports share the same lookup.
  always_comb begin
    {qry_ready_a, qry_value_a} = lookup(qry_tag_a);
    {qry_ready_b, qry_value_b} = lookup(qry_tag_b);
  end
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios plus randomized traffic, checked every cycle
// against a program-order queue model of the reorder buffer.
module tb_rob_multiport;
  localparam int unsigned D  = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned NP = 2;
  localparam logic [2:0]  ST = 3'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rdy, flush, iss_valid, iss_ready, done;
  logic [31:0]       iss_pc;
  logic [4:0]        iss_rd;
  logic [5:0]        iss_op;
  logic [2:0]        iss_type;
  logic [TW-1:0]     iss_tag;
  logic [NP-1:0]     cdb_valid;
  logic [NP*TW-1:0]  cdb_tag;
  logic [NP*32-1:0]  cdb_value, cdb_pc_res;
  logic              cmt_valid, empty;
  logic [TW-1:0]     cmt_tag;
  logic [4:0]        cmt_rd;
  logic [5:0]        cmt_op;
  logic [2:0]        cmt_type;
  logic [31:0]       cmt_value, cmt_pc, cmt_pc_res;
  logic [TW:0]       occupancy;
`ifdef ROB_QUERY_EN
  logic              qry_ready_a, qry_ready_b;
  logic [31:0]       qry_value_a, qry_value_b;
`endif

  rob_multiport #(.ROB_DEPTH(D), .TAG_W(TW), .CDB_PORTS(NP), .STORE_TYPE(ST)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_rd(iss_rd), .iss_op(iss_op),
    .iss_type(iss_type), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_pc_res(cdb_pc_res),
    .store_done_in(done),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_rd(cmt_rd), .cmt_op(cmt_op),
    .cmt_type(cmt_type), .cmt_value(cmt_value), .cmt_pc(cmt_pc), .cmt_pc_res(cmt_pc_res),
    .occupancy(occupancy),
`ifdef ROB_QUERY_EN
    .qry_tag_a('0), .qry_tag_b('0), .qry_ready_a(qry_ready_a), .qry_ready_b(qry_ready_b),
    .qry_value_a(qry_value_a), .qry_value_b(qry_value_b),
`endif
    .empty(empty)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [2:0]  typ;
    bit          rdy;
    logic [31:0] val;
    logic [31:0] pcr;
  } ent_t;

  ent_t mq[$];
  int   m_next = 0;
  bit   m_sp   = 1'b0;
  bit   e_cv   = 1'b0;
  ent_t e_cmt  = '{default: 0};

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_can_retire();
    return (mq.size() > 0) && mq[0].rdy && !m_sp;
  endfunction

  function automatic bit m_iss_ready();
    return (mq.size() < int'(D)) || m_can_retire();
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   ret, acc, set;
    int   t;
    ent_t h;
    if (rst) begin
      mq.delete();
      m_next = 0;
      m_sp   = 1'b0;
      e_cv   = 1'b0;
      e_cmt  = '{default: 0};
    end else if (rdy) begin
      e_cv = 1'b0;
      set  = 1'b0;
      if (flush) begin
        mq.delete();
        m_next = 0;
      end else begin
        ret = m_can_retire();
        acc = iss_valid && m_iss_ready();
        h   = '{default: 0};
        if (ret) h = mq[0];
        for (int p = 0; p < int'(NP); p++) begin
          if (cdb_valid[p]) begin
            t = int'(cdb_tag[p*TW +: TW]);
            foreach (mq[i]) begin
              if (mq[i].tag == t) begin
                mq[i].rdy = 1'b1;
                mq[i].val = cdb_value[p*32 +: 32];
                mq[i].pcr = cdb_pc_res[p*32 +: 32];
              end
            end
          end
        end
        if (ret) begin
          e_cv  = 1'b1;
          e_cmt = h;
          void'(mq.pop_front());
          set = (h.typ == ST);
        end
        if (acc) begin
          mq.push_back('{tag: m_next, pc: iss_pc, rd: iss_rd, op: iss_op, typ: iss_type,
                         rdy: 1'b0, val: 32'd0, pcr: 32'd0});
          m_next = (m_next + 1) % int'(D);
        end
      end
      if (set) m_sp = 1'b1;
      else if (done) m_sp = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("cmt_valid",  64'(cmt_valid),  64'(e_cv));
    check_eq("cmt_tag",    64'(cmt_tag),    64'(e_cmt.tag));
    check_eq("cmt_rd",     64'(cmt_rd),     64'(e_cmt.rd));
    check_eq("cmt_op",     64'(cmt_op),     64'(e_cmt.op));
    check_eq("cmt_type",   64'(cmt_type),   64'(e_cmt.typ));
    check_eq("cmt_value",  64'(cmt_value),  64'(e_cmt.val));
    check_eq("cmt_pc",     64'(cmt_pc),     64'(e_cmt.pc));
    check_eq("cmt_pc_res", 64'(cmt_pc_res), 64'(e_cmt.pcr));
    check_eq("occupancy",  64'(occupancy),  64'(mq.size()));
    check_eq("empty",      64'(empty),      64'(mq.size() == 0));
    check_eq("iss_tag",    64'(iss_tag),    64'(m_next));
    check_eq("iss_ready",  64'(iss_ready),  64'(m_iss_ready()));
  endtask

  task automatic set_idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; done = 1'b0;
    iss_valid = 1'b0; iss_pc = '0; iss_rd = '0; iss_op = '0; iss_type = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_pc_res = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    set_idle();
  endtask

  task automatic drive_alloc(input logic [2:0] typ);
    iss_valid = 1'b1;
    iss_pc    = $urandom;
    iss_rd    = 5'($urandom);
    iss_op    = 6'($urandom);
    iss_type  = typ;
  endtask

  task automatic drive_cdb(input int p, input int tag, input logic [31:0] val);
    cdb_valid[p]           = 1'b1;
    cdb_tag[p*TW +: TW]    = TW'(tag);
    cdb_value[p*32 +: 32]  = val;
    cdb_pc_res[p*32 +: 32] = val ^ 32'h5A5A_0000;
  endtask

  initial begin
    set_idle();
    // Reset
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    check_eq("rst_empty",  64'(empty),     64'(1));
    check_eq("rst_ready",  64'(iss_ready), 64'(1));
    check_eq("rst_cmt",    64'(cmt_valid), 64'(0));

    // Fill to capacity; 33rd allocation is refused
    for (int i = 0; i < 32; i++) begin drive_alloc(3'd0); tick(); end
    check_eq("fill_ready", 64'(iss_ready), 64'(0));
    check_eq("fill_occ",   64'(occupancy), 64'(32));
    check_eq("fill_tag",   64'(iss_tag),   64'(0));
    drive_alloc(3'd0); tick();
    check_eq("fill_33rd",  64'(occupancy), 64'(32));
    flush = 1'b1; tick();

    // Out-of-order completion, in-order retirement
    for (int i = 0; i < 3; i++) begin drive_alloc(3'd0); tick(); end
    drive_cdb(0, 2, 32'h2); tick();
    drive_cdb(0, 1, 32'h1); tick();
    drive_cdb(0, 0, 32'hA); tick();
    check_eq("ooo_none", 64'(cmt_valid), 64'(0));
    tick();
    check_eq("ooo_tag0", 64'(cmt_tag),   64'(0));
    check_eq("ooo_val0", 64'(cmt_value), 64'(32'hA));
    tick();
    check_eq("ooo_tag1", 64'(cmt_tag),   64'(1));
    tick();
    check_eq("ooo_tag2", 64'(cmt_tag),   64'(2));

    // Two ports in one cycle, then both ports on the same tag
    drive_alloc(3'd0); tick();
    drive_alloc(3'd0); tick();
    drive_cdb(0, 3, 32'h33); drive_cdb(1, 4, 32'h44); tick();
    tick(); check_eq("dual_t3", 64'(cmt_tag), 64'(3));
    tick(); check_eq("dual_t4", 64'(cmt_tag), 64'(4));
    drive_alloc(3'd0); tick();
    drive_cdb(0, 5, 32'h111); drive_cdb(1, 5, 32'h222); tick();
    tick(); check_eq("same_tag", 64'(cmt_value), 64'(32'h222));

    // Store holds the next retirement until completion
    flush = 1'b1; tick();
    drive_alloc(ST); tick();
    drive_alloc(3'd0); tick();
    drive_cdb(0, 0, 32'h50); drive_cdb(1, 1, 32'h51); tick();
    tick(); check_eq("st_ret", 64'(cmt_tag), 64'(0));
    for (int i = 0; i < 3; i++) begin tick(); check_eq("st_hold", 64'(cmt_valid), 64'(0)); end
    done = 1'b1; tick();
    check_eq("st_done", 64'(cmt_valid), 64'(0));
    tick(); check_eq("st_next", 64'(cmt_valid), 64'(1));

    // Flush while a store is outstanding
    drive_alloc(ST); tick();
    drive_cdb(0, 2, 32'h77); tick();
    tick(); check_eq("fs_store", 64'(cmt_valid), 64'(1));
    flush = 1'b1; tick();
    check_eq("fs_tag0", 64'(iss_tag), 64'(0));
    for (int i = 0; i < 4; i++) begin drive_alloc(3'd1); tick(); end
    drive_cdb(0, 0, 32'h90); drive_cdb(1, 1, 32'h91); tick();
    drive_cdb(0, 2, 32'h92); drive_cdb(1, 3, 32'h93); tick();
    for (int i = 0; i < 3; i++) begin tick(); check_eq("fs_hold", 64'(cmt_valid), 64'(0)); end
    done = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin tick(); check_eq("fs_drain", 64'(cmt_tag), 64'(i)); end

    // Allocate and retire together while full
    flush = 1'b1; tick();
    for (int i = 0; i < 32; i++) begin drive_alloc(3'd0); tick(); end
    drive_cdb(1, 0, 32'hF0); tick();
    check_eq("full_ready", 64'(iss_ready), 64'(1));
    drive_alloc(3'd0); tick();
    check_eq("full_occ", 64'(occupancy), 64'(32));
    check_eq("full_cmt", 64'(cmt_valid), 64'(1));

    // Reset in the middle of filling
    flush = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin drive_alloc(3'd0); tick(); end
    rst = 1'b1; drive_alloc(3'd0); tick();
    check_eq("mid_empty", 64'(empty),     64'(1));
    check_eq("mid_cmt",   64'(cmt_valid), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(9) != 0);
      flush = ($urandom_range(99) == 0);
      rst   = ($urandom_range(299) == 0);
      done  = ($urandom_range(5) == 0);
      if ($urandom_range(9) < 6) drive_alloc(3'($urandom));
      for (int p = 0; p < int'(NP); p++) begin
        if ($urandom_range(2) != 0) begin
          if (mq.size() > 0 && $urandom_range(3) != 0)
            drive_cdb(p, mq[$urandom_range(mq.size() - 1)].tag, $urandom);
          else
            drive_cdb(p, int'($urandom_range(D - 1)), $urandom);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
